fifo_spram_fwft: RTL and testbench
==================================

// Module: fifo_spram_fwft
// PURPOSE
//  Next-generation SPRAM-backed FIFO: parametrised width/depth over 1-4 SB_SPRAM256KA banks.
//  First-word-fall-through output with empty-FIFO bypass. Occupancy level and almost_full.
//  Sticky overflow/underflow flags and synchronous flush.
//  Sits between uart_rx (producer) and uart_tx or any other consumer; single RAM port arbitrated internally.
// PARAMETERS
//  WIDTH      8   data bits per entry, 1..16; stored in a 16-bit SPRAM word, upper bits zero-padded and masked
//  BANKS      1   number of SPRAM blocks, 1/2/4; DEPTH = 16384*BANKS words
//  AF_THRESH  DEPTH-16  almost_full asserts when level >= AF_THRESH
// PORTS
//  clk             in   1        system clock (48 MHz HFOSC)
//  reset           in   1        asynchronous, active-high reset
//  write_data      in   WIDTH    entry to enqueue
//  write_strobe    in   1        one-cycle enqueue request
//  write_ready     out  1        !full
//  read_data       out  WIDTH    head entry, valid while data_available
//  read_strobe     in   1        one-cycle dequeue of head
//  data_available  out  1        head register holds a valid entry
//  level           out  LW       total stored entries, 0..DEPTH; LW = clog2(DEPTH+1)
//  almost_full     out  1        level >= AF_THRESH
//  overflow        out  1        sticky: write attempted while full
//  underflow       out  1        sticky: read attempted while !data_available
//  clear_errors    in   1        clears overflow/underflow next edge
//  flush           in   1        synchronous empty
// BEHAVIOUR
//  Reset (async): wr_ptr=rd_ptr=0, level=0, head empty, no read in flight.
//   Outputs: data_available=0, read_data=0, write_ready=1, almost_full=0, overflow=underflow=0.
//  Storage: RAM ring addressed by wr_ptr/rd_ptr (clog2(DEPTH) bits, natural wrap); bank = ptr MSBs.
//   level counts RAM words + head + in-flight word.
//  RAM port, one op per cycle, priority: (1) write, (2) prefetch read. Writes never stall.
//  Prefetch: issued when RAM holds >=1 word, no read in flight, no write this cycle,
//   and (head empty or read_strobe this cycle).
//   Address sampled edge E1; SPRAM DATAOUT loaded into head at E2; data_available high after E2.
//   Sustained read throughput = 1 word / 2 cycles; continuous writes starve prefetch (documented).
//  Bypass: if RAM empty and no read in flight, and either (head empty) or (head valid and read_strobe),
//   a write loads write_data straight into head. data_available high the following cycle; RAM untouched.
//  Simultaneous write+read: both honoured in the same cycle. level unchanged, except:
//   - write while full: write dropped, read honoured.
//   - read while empty: read ignored, write honoured.
//  Full: level==DEPTH -> write_ready=0; write_strobe dropped, overflow<=1, no pointer/level change.
//  Empty read: read_strobe with data_available=0 -> underflow<=1, no state change.
//  flush: wins over everything. Next edge: pointers/level reset, head cleared, in-flight discarded
//   (its returning data ignored); overflow/underflow kept.
//  clear_errors: clears both sticky flags. A same-cycle error event wins (flag stays 1).
//  Reset mid-operation: everything returns to reset state immediately; RAM contents are don't-care.
//  level/almost_full/write_ready are registered and updated on the same edge as the causing event.
// STRUCTURE
//  Shared header fifo_spram_defs.vh: SPRAM_WORDS (16384), SPRAM_DW (16), clog2 macro, bank-select width.
//  Sub-module spram_banked: BANKS x SB_SPRAM256KA.
//   Ports: addr, wdata, we, re, rdata.
//   Decodes bank from upper addr bits, registers bank select for read-data mux, MASKWREN=4'b1111.
//  Top: pointer/level counters, arbitration, head register, in-flight flag, sticky flags.
// TESTING
//  1. Reset, write 0x41 once -> data_available=1 one cycle later, read_data=0x41 (bypass); RAM we never asserts.
//  2. Write 0x00..0x09 back-to-back, then read all -> in-order 0x00..0x09; level 10->0; no flags set.
//  3. BANKS=2: fill to DEPTH=32768 -> write_ready=0. Extra write -> overflow=1, level stays 32768.
//     Drain -> data intact across bank boundary 16383/16384.
//  4. Level 5, simultaneous write+read every cycle for 100 cycles -> level stays 5; output sequence unbroken.
//  5. read_strobe while empty -> underflow=1. clear_errors -> 0 next edge. Coincident error+clear -> stays 1.
//  6. Issue prefetch then flush same cycle; separately assert reset mid-fill.
//     -> level=0, data_available=0; stale RAM data never appears on read_data.

Source files
------------

// File: rtl/fifo_spram_fwft_pkg.sv
// Shared constants and types for the SPRAM-backed first-word-fall-through FIFO.
// One SPRAM block is 16384 x 16; bank index comes from the address bits above that.
package fifo_spram_fwft_pkg;

    localparam int unsigned SPRAM_WORDS = 16384;
    localparam int unsigned SPRAM_DW    = 16;
    localparam int unsigned SPRAM_AW    = $clog2(SPRAM_WORDS);

    // Head register: empty, waiting on a RAM read, or holding the next entry.
    typedef enum logic [1:0] {
        HEAD_EMPTY,
        HEAD_PENDING,
        HEAD_VALID
    } head_state_t;

    function automatic int unsigned bank_bits(input int unsigned banks);
        return (banks > 1) ? $clog2(banks) : 1;
    endfunction

endpackage

// File: rtl/fifo_spram_fwft_spram_banked.sv
// BANKS x 16384x16 single-port RAM with registered read data, shaped like SB_SPRAM256KA
// (all nibbles write-enabled); bank decoded from the upper address bits.
module fifo_spram_fwft_spram_banked
    import fifo_spram_fwft_pkg::*;
#(
    parameter int unsigned BANKS = 1
) (
    input  logic                                 clk,
    input  logic [$clog2(SPRAM_WORDS*BANKS)-1:0] addr,
    input  logic [SPRAM_DW-1:0]                  wdata,
    input  logic                                 we,
    input  logic                                 re,
    output logic [SPRAM_DW-1:0]                  rdata
);

    localparam int unsigned BW = bank_bits(BANKS);

    logic [BW-1:0]       bank_sel;
    logic [BW-1:0]       bank_q;
    logic [SPRAM_AW-1:0] offs;
    logic [SPRAM_DW-1:0] bank_dout [BANKS];

    assign offs     = addr[SPRAM_AW-1:0];
    assign bank_sel = BW'(addr >> SPRAM_AW);

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic [SPRAM_DW-1:0] mem [SPRAM_WORDS];
        logic [SPRAM_DW-1:0] dout;
        logic                hit;

        assign hit = (bank_sel == BW'(b));

        always_ff @(posedge clk) begin
            if (we && hit) mem[offs] <= wdata;
            if (re && hit) dout <= mem[offs];
        end

        assign bank_dout[b] = dout;
    end

    // Bank select is held with the read so the output mux follows the data, not the address.
    always_ff @(posedge clk) begin
        if (re) bank_q <= bank_sel;
    end

    always_comb begin
        rdata = '0;
        for (int unsigned i = 0; i < BANKS; i++) begin
            if (bank_q == BW'(i)) rdata = bank_dout[i];
        end
    end

endmodule

// File: rtl/fifo_spram_fwft.sv
// SPRAM-backed FWFT FIFO: single RAM port shared between writes and head prefetch,
// empty-FIFO bypass into the head register, occupancy level and sticky error flags.
module fifo_spram_fwft
    import fifo_spram_fwft_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned BANKS     = 1,
    parameter int unsigned AF_THRESH = SPRAM_WORDS * BANKS - 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [WIDTH-1:0]                       write_data,
    input  logic                                   write_strobe,
    output logic                                   write_ready,
    output logic [WIDTH-1:0]                       read_data,
    input  logic                                   read_strobe,
    output logic                                   data_available,
    output logic [$clog2(SPRAM_WORDS*BANKS+1)-1:0] level,
    output logic                                   almost_full,
    output logic                                   overflow,
    output logic                                   underflow,
    input  logic                                   clear_errors,
    input  logic                                   flush
);

    localparam int unsigned DEPTH = SPRAM_WORDS * BANKS;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LW    = $clog2(DEPTH + 1);

    head_state_t         head_st, head_nxt;
    logic [AW-1:0]       wr_ptr, rd_ptr, ram_addr;
    logic [LW-1:0]       ram_cnt, level_nxt;
    logic                full, rd_ok, wr_ok, bypass, ram_we, prefetch;
    logic [SPRAM_DW-1:0] ram_rdata;
    logic                unused_rdata;

    always_comb begin
        full      = (level == LW'(DEPTH));
        rd_ok     = read_strobe && (head_st == HEAD_VALID);
        wr_ok     = write_strobe && !full;
        bypass    = wr_ok && (ram_cnt == '0) && (head_st == HEAD_EMPTY || rd_ok);
        ram_we    = wr_ok && !bypass && !flush;
        prefetch  = (ram_cnt != '0) && !ram_we && !flush && (head_st == HEAD_EMPTY || rd_ok);
        level_nxt = level + LW'(wr_ok) - LW'(rd_ok);
        ram_addr  = ram_we ? wr_ptr : rd_ptr;
    end

    // A pending read always lands next edge; otherwise prefetch, bypass and plain pop are exclusive.
    always_comb begin
        head_nxt = head_st;
        case (head_st)
            HEAD_PENDING: head_nxt = HEAD_VALID;
            default: begin
                if (prefetch)    head_nxt = HEAD_PENDING;
                else if (bypass) head_nxt = HEAD_VALID;
                else if (rd_ok)  head_nxt = HEAD_EMPTY;
            end
        endcase
    end

    fifo_spram_fwft_spram_banked #(
        .BANKS(BANKS)
    ) u_ram (
        .clk  (clk),
        .addr (ram_addr),
        .wdata(SPRAM_DW'(write_data)),
        .we   (ram_we),
        .re   (prefetch),
        .rdata(ram_rdata)
    );

    assign unused_rdata = ^ram_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            ram_cnt        <= '0;
            level          <= '0;
            head_st        <= HEAD_EMPTY;
            data_available <= 1'b0;
            read_data      <= '0;
            write_ready    <= 1'b1;
            almost_full    <= 1'b0;
            overflow       <= 1'b0;
            underflow      <= 1'b0;
        end else if (flush) begin
            // Sticky flags survive a flush; any returning RAM word is ignored.
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            ram_cnt        <= '0;
            level          <= '0;
            head_st        <= HEAD_EMPTY;
            data_available <= 1'b0;
            read_data      <= '0;
            write_ready    <= 1'b1;
            almost_full    <= 1'b0;
        end else begin
            if (ram_we)   wr_ptr <= wr_ptr + AW'(1);
            if (prefetch) rd_ptr <= rd_ptr + AW'(1);
            ram_cnt        <= ram_cnt + LW'(ram_we) - LW'(prefetch);
            level          <= level_nxt;
            write_ready    <= (level_nxt != LW'(DEPTH));
            almost_full    <= (level_nxt >= LW'(AF_THRESH));
            head_st        <= head_nxt;
            data_available <= (head_nxt == HEAD_VALID);
            if (head_st == HEAD_PENDING) read_data <= ram_rdata[WIDTH-1:0];
            else if (bypass)             read_data <= write_data;

            if (write_strobe && full)                  overflow <= 1'b1;
            else if (clear_errors)                     overflow <= 1'b0;
            if (read_strobe && head_st != HEAD_VALID)  underflow <= 1'b1;
            else if (clear_errors)                     underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_spram_fwft.sv
// Bench for fifo_spram_fwft (WIDTH=8, BANKS=2): directed steps plus random traffic,
// checked against a queue model of the FIFO contents and sticky flags.
module tb_fifo_spram_fwft;

    localparam int DEPTH = 32768;
    localparam int AF    = DEPTH - 16;

    logic        clk;
    logic        reset;
    logic [7:0]  write_data;
    logic        write_strobe;
    logic        write_ready;
    logic [7:0]  read_data;
    logic        read_strobe;
    logic        data_available;
    logic [15:0] level;
    logic        almost_full;
    logic        overflow;
    logic        underflow;
    logic        clear_errors;
    logic        flush;

    int          checks = 0;
    int          errors = 0;
    int          we_count = 0;
    logic [7:0]  mq [$];
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;

    fifo_spram_fwft #(
        .WIDTH    (8),
        .BANKS    (2),
        .AF_THRESH(AF)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .write_data    (write_data),
        .write_strobe  (write_strobe),
        .write_ready   (write_ready),
        .read_data     (read_data),
        .read_strobe   (read_strobe),
        .data_available(data_available),
        .level         (level),
        .almost_full   (almost_full),
        .overflow      (overflow),
        .underflow     (underflow),
        .clear_errors  (clear_errors),
        .flush         (flush)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (dut.ram_we) we_count <= we_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check head against model, clock, update model, check state.
    task automatic tick(input logic wr, input logic [7:0] d, input logic rd,
                        input logic clr, input logic fl);
        logic avail;
        logic was_full;
        write_strobe = wr;
        write_data   = d;
        read_strobe  = rd;
        clear_errors = clr;
        flush        = fl;
        avail    = data_available;
        was_full = (mq.size() == DEPTH);
        if (avail) begin
            check("avail_nonempty", 32'(avail), 32'(mq.size() != 0));
            if (mq.size() != 0) check("head_data", 32'(read_data), 32'(mq[0]));
        end
        @(posedge clk);
        #1;
        if (fl) begin
            mq.delete();
        end else begin
            if (rd && avail) void'(mq.pop_front());
            if (wr && !was_full) mq.push_back(d);
            m_ovf = (wr && was_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
            m_unf = (rd && !avail)   ? 1'b1 : (clr ? 1'b0 : m_unf);
        end
        write_strobe = 1'b0;
        read_strobe  = 1'b0;
        clear_errors = 1'b0;
        flush        = 1'b0;
        check("level",       32'(level),       32'(mq.size()));
        check("write_ready", 32'(write_ready), 32'(mq.size() != DEPTH));
        check("almost_full", 32'(almost_full), 32'(mq.size() >= AF));
        check("overflow",    32'(overflow),    32'(m_ovf));
        check("underflow",   32'(underflow),   32'(m_unf));
    endtask

    task automatic wait_avail(input string tag);
        int n = 0;
        while (!data_available && n < 8) begin
            tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            n++;
        end
        check(tag, 32'(data_available), 32'd1);
    endtask

    initial begin
        logic [7:0] r;
        int         w0;

        reset        = 1'b1;
        write_data   = '0;
        write_strobe = 1'b0;
        read_strobe  = 1'b0;
        clear_errors = 1'b0;
        flush        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_avail",  32'(data_available), 32'd0);
        check("rst_rdata",  32'(read_data),      32'd0);
        check("rst_wready", 32'(write_ready),    32'd1);
        check("rst_af",     32'(almost_full),    32'd0);
        check("rst_ovf",    32'(overflow),       32'd0);
        check("rst_unf",    32'(underflow),      32'd0);
        check("rst_level",  32'(level),          32'd0);
        reset = 1'b0;

        // Bypass of a single write into an empty FIFO
        w0 = we_count;
        tick(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
        check("bypass_avail", 32'(data_available), 32'd1);
        check("bypass_data",  32'(read_data),      32'h41);
        check("bypass_no_we", 32'(we_count),       32'(w0));
        tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Back-to-back writes then in-order drain
        for (int i = 0; i < 10; i++) tick(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        check("burst_level", 32'(level), 32'd10);
        for (int i = 0; i < 10; i++) begin
            wait_avail("burst_wait");
            check("burst_seq", 32'(read_data), 32'(i));
            tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        check("burst_empty", 32'(level), 32'd0);

        // Level held at 5 across 100 simultaneous write+read transfers
        for (int i = 0; i < 5; i++) tick(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            wait_avail("steady_wait");
            r = 8'($urandom);
            tick(1'b1, r, 1'b1, 1'b0, 1'b0);
        end
        check("steady_level", 32'(level), 32'd5);
        for (int i = 0; i < 5; i++) begin
            wait_avail("steady_drain");
            tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end

        // Underflow, clear, and error coinciding with clear
        tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("unf_set", 32'(underflow), 32'd1);
        tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("unf_clr", 32'(underflow), 32'd0);
        tick(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        check("unf_win", 32'(underflow), 32'd1);
        tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Fill to full, overflow, drain across bank boundary
        for (int i = 0; i < DEPTH; i++) tick(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        check("full_wready", 32'(write_ready), 32'd0);
        check("full_level",  32'(level),       32'(DEPTH));
        check("full_af",     32'(almost_full), 32'd1);
        tick(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        check("ovf_set",   32'(overflow), 32'd1);
        check("ovf_level", 32'(level),    32'(DEPTH));
        for (int i = 0; i < 16400; i++) begin
            wait_avail("drain_wait");
            tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("flush_level", 32'(level), 32'd0);

        // Flush coinciding with a read that launches a prefetch
        tick(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("flushA_avail", 32'(data_available), 32'd0);
            tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        end
        // Flush while the prefetched word is in flight
        tick(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("flushB_avail", 32'(data_available), 32'd0);
            tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        end
        tick(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        check("post_flush_data", 32'(read_data), 32'hA5);
        tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a fill
        for (int i = 0; i < 20; i++) tick(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        check("arst_level",  32'(level),          32'd0);
        check("arst_avail",  32'(data_available), 32'd0);
        check("arst_wready", 32'(write_ready),    32'd1);
        check("arst_rdata",  32'(read_data),      32'd0);
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        check("arst_bypass", 32'(read_data), 32'h5A);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(49) == 0) begin
                tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            end else begin
                tick(1'($urandom_range(1)), 8'($urandom), 1'($urandom_range(1)),
                     1'($urandom_range(9) == 0), 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
